// File: rtl/stitch_pipeline_vr_pkg.sv
// Shared types and helpers for the stitched valid/ready pipeline.
// The stage increment is computed here so every stage derives it the same way.
package stitch_pipeline_pkg;

    localparam int MAX_INCR_WIDTH = 256;

    typedef logic [MAX_INCR_WIDTH-1:0] incr_t;

    // Stage k adds 2^k; stages at or beyond the word width pass data through.
    function automatic incr_t stage_incr(input int k, input int width);
        if (k >= width || k >= MAX_INCR_WIDTH) begin
            return '0;
        end
        return incr_t'(1) << k;
    endfunction

    function automatic int occ_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/stitch_pipeline_vr_stage.sv
// One combinational compute stage: out_data = in_data + 2^STAGE_IDX (mod 2^WIDTH).
module stitch_pipeline_stage
    import stitch_pipeline_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGE_IDX = 0
) (
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [WIDTH-1:0] INCR = WIDTH'(stage_incr(STAGE_IDX, WIDTH));

    assign out_data = in_data + INCR;

endmodule

// File: rtl/stitch_pipeline_vr.sv
// Parametrised stitched pipeline with per-slot valid/ready and bubble collapsing.
// Optional occupancy output enabled by macro STITCH_PIPELINE_VR_OCCUPANCY_EN.
module stitch_pipeline_vr
    import stitch_pipeline_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      out_data
`ifdef STITCH_PIPELINE_VR_OCCUPANCY_EN
    ,
    output logic [occ_width(NUM_STAGES)-1:0]      occupancy
`endif
);

    localparam int N = NUM_STAGES;

    logic [N:0]       valid_q;
    logic [WIDTH-1:0] data_q    [0:N];
    logic [WIDTH-1:0] stage_out [0:N-1];
    logic [N:0]       rdy;

    // A slot may load when the consumer takes a word or any slot at or below
    // it (towards the output) is empty; this is the unrolled ready chain.
    for (genvar k = 0; k <= N; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~(&valid_q[N:k]);
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        stitch_pipeline_stage #(
            .WIDTH     (WIDTH),
            .STAGE_IDX (k)
        ) u_stage (
            .in_data  (data_q[k]),
            .out_data (stage_out[k])
        );
    end

    assign in_ready  = rdy[0] & ~rst;
    assign out_valid = valid_q[N] & ~rst;
    assign out_data  = data_q[N];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (rdy[0]) begin
                valid_q[0] <= in_valid;
            end
            for (int k = 1; k <= N; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    // NOTE: data slots carry no reset; valid_q alone qualifies them, so the
    // datapath avoids reset fan-out.
    always_ff @(posedge clk) begin
        if (rdy[0]) begin
            data_q[0] <= in_data;
        end
        for (int k = 1; k <= N; k++) begin
            if (rdy[k]) begin
                data_q[k] <= stage_out[k-1];
            end
        end
    end

`ifdef STITCH_PIPELINE_VR_OCCUPANCY_EN
    localparam int OCC_W = occ_width(N);

    logic [OCC_W-1:0] occ_q;
    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (xfer_in && !xfer_out) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (xfer_out && !xfer_in) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
        occ_q == OCC_W'($countones(valid_q)));
`endif

endmodule
